// File: rtl/wb_stage_param.sv
// Write-back pipeline stage: selects and extends load data, picks the write-back
// source and next PC, and registers everything with a retired-instruction counter.
module wb_stage_param #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = {XLEN{1'b0}}
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_i,
  input  logic            stall_i,
  input  logic            flush_i,
  input  logic [XLEN-1:0] alu_i,
  input  logic [XLEN-1:0] mem_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] imm_i,
  input  logic [1:0]      wb_sel_i,
  input  logic [2:0]      load_type_i,
  input  logic [4:0]      rd_i,
  input  logic            reg_we_i,
  input  logic            pc_sel_i,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] dataD_o,
  output logic [4:0]      rd_o,
  output logic            reg_we_o,
  output logic            valid_o,
  output logic [XLEN-1:0] instret_o
);

  localparam logic [XLEN-1:0] ONE  = {{(XLEN-1){1'b0}}, 1'b1};
  localparam logic [XLEN-1:0] FOUR = {{(XLEN-3){1'b0}}, 3'b100};

  logic [7:0]      byte_s;
  logic [15:0]     half_s;
  logic [XLEN-1:0] load_s;
  logic [XLEN-1:0] pc_plus4_s;
  logic [XLEN-1:0] next_pc_s;
  logic [XLEN-1:0] wb_data_s;
  logic            rd_we_s;

  // Load extraction, write-back source mux and next-PC selection
  always_comb begin
    byte_s     = 8'h00;
    half_s     = 16'h0000;
    load_s     = mem_i;
    pc_plus4_s = pc_i + FOUR;
    next_pc_s  = pc_plus4_s;
    wb_data_s  = alu_i;
    rd_we_s    = reg_we_i & (rd_i != 5'd0);

    case (alu_i[1:0])
      2'b00:   byte_s = mem_i[7:0];
      2'b01:   byte_s = mem_i[15:8];
      2'b10:   byte_s = mem_i[23:16];
      2'b11:   byte_s = mem_i[31:24];
      default: byte_s = 8'h00;
    endcase

    if (alu_i[1]) begin
      half_s = mem_i[31:16];
    end else begin
      half_s = mem_i[15:0];
    end

    // Reserved encodings fall through to a full-word load
    case (load_type_i)
      3'b000:  load_s = {{(XLEN-8){byte_s[7]}}, byte_s};
      3'b001:  load_s = {{(XLEN-16){half_s[15]}}, half_s};
      3'b100:  load_s = {{(XLEN-8){1'b0}}, byte_s};
      3'b101:  load_s = {{(XLEN-16){1'b0}}, half_s};
      default: load_s = mem_i;
    endcase

    if (pc_sel_i) begin
      next_pc_s = {alu_i[XLEN-1:1], 1'b0};
    end else begin
      next_pc_s = pc_plus4_s;
    end

    case (wb_sel_i)
      2'b00:   wb_data_s = alu_i;
      2'b01:   wb_data_s = load_s;
      2'b10:   wb_data_s = pc_plus4_s;
      2'b11:   wb_data_s = imm_i;
      default: wb_data_s = alu_i;
    endcase
  end

  // Stage registers: flush beats stall, stall beats accept, otherwise a bubble
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_o      <= RESET_PC;
      dataD_o   <= {XLEN{1'b0}};
      rd_o      <= 5'd0;
      reg_we_o  <= 1'b0;
      valid_o   <= 1'b0;
      instret_o <= {XLEN{1'b0}};
    end else if (flush_i) begin
      reg_we_o <= 1'b0;
      valid_o  <= 1'b0;
    end else if (stall_i) begin
      reg_we_o <= reg_we_o;
      valid_o  <= valid_o;
    end else if (valid_i) begin
      pc_o      <= next_pc_s;
      dataD_o   <= wb_data_s;
      rd_o      <= rd_i;
      reg_we_o  <= rd_we_s;
      valid_o   <= 1'b1;
      instret_o <= instret_o + ONE;
    end else begin
      reg_we_o <= 1'b0;
      valid_o  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_wb_stage_param.sv
// Self-checking bench for wb_stage_param: directed cases plus randomized traffic
// compared against an arithmetic reference model of the stage.
module tb_wb_stage_param;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i, stall_i, flush_i;
  logic [31:0] alu_i, mem_i, pc_i, imm_i;
  logic [1:0]  wb_sel_i;
  logic [2:0]  load_type_i;
  logic [4:0]  rd_i;
  logic        reg_we_i, pc_sel_i;
  logic [31:0] pc_o, dataD_o, instret_o;
  logic [4:0]  rd_o;
  logic        reg_we_o, valid_o;

  // Reference model state
  logic [31:0] m_pc, m_data, m_instret;
  logic [4:0]  m_rd;
  logic        m_we, m_valid;

  int checks_cnt = 0;
  int errors_cnt = 0;

  always #5 clk = ~clk;

  wb_stage_param #(.XLEN(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .stall_i(stall_i), .flush_i(flush_i),
    .alu_i(alu_i), .mem_i(mem_i), .pc_i(pc_i), .imm_i(imm_i), .wb_sel_i(wb_sel_i),
    .load_type_i(load_type_i), .rd_i(rd_i), .reg_we_i(reg_we_i), .pc_sel_i(pc_sel_i),
    .pc_o(pc_o), .dataD_o(dataD_o), .rd_o(rd_o), .reg_we_o(reg_we_o),
    .valid_o(valid_o), .instret_o(instret_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_cnt++;
    if (obs !== exp) begin
      errors_cnt++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_load(input logic [2:0] lt, input logic [31:0] m,
                                           input logic [31:0] a);
    logic [31:0] v;
    case (lt)
      3'd0: begin v = (m >> (8 * a[1:0])) & 32'hFF;   if (v[7])  v = v | 32'hFFFF_FF00; end
      3'd4: v = (m >> (8 * a[1:0])) & 32'hFF;
      3'd1: begin v = (m >> (16 * a[1])) & 32'hFFFF;  if (v[15]) v = v | 32'hFFFF_0000; end
      3'd5: v = (m >> (16 * a[1])) & 32'hFFFF;
      default: v = m;
    endcase
    return v;
  endfunction

  task automatic model_reset();
    m_pc = 32'h0; m_data = 32'h0; m_rd = 5'd0; m_we = 1'b0; m_valid = 1'b0; m_instret = 32'h0;
  endtask

  task automatic model_step();
    if (flush_i || (!stall_i && !valid_i)) begin
      m_valid = 1'b0;
      m_we    = 1'b0;
    end else if (!stall_i) begin
      m_pc = pc_sel_i ? (alu_i & 32'hFFFF_FFFE) : pc_i + 32'd4;
      case (wb_sel_i)
        2'd0: m_data = alu_i;
        2'd1: m_data = ref_load(load_type_i, mem_i, alu_i);
        2'd2: m_data = pc_i + 32'd4;
        default: m_data = imm_i;
      endcase
      m_rd      = rd_i;
      m_we      = reg_we_i && (rd_i != 5'd0);
      m_valid   = 1'b1;
      m_instret = m_instret + 32'd1;
    end
  endtask

  task automatic check_all(input string pfx);
    chk({pfx, ".pc"},      pc_o,               m_pc);
    chk({pfx, ".data"},    dataD_o,            m_data);
    chk({pfx, ".rd"},      {27'd0, rd_o},      {27'd0, m_rd});
    chk({pfx, ".we"},      {31'd0, reg_we_o},  {31'd0, m_we});
    chk({pfx, ".valid"},   {31'd0, valid_o},   {31'd0, m_valid});
    chk({pfx, ".instret"}, instret_o,          m_instret);
  endtask

  task automatic drive(input logic v, s, f, input logic [31:0] alu, mem, pc, imm,
                       input logic [1:0] sel, input logic [2:0] lt, input logic [4:0] rd,
                       input logic we, psel);
    valid_i = v; stall_i = s; flush_i = f; alu_i = alu; mem_i = mem; pc_i = pc; imm_i = imm;
    wb_sel_i = sel; load_type_i = lt; rd_i = rd; reg_we_i = we; pc_sel_i = psel;
  endtask

  task automatic cycle(input string pfx);
    model_step();
    @(posedge clk);
    #1;
    check_all(pfx);
  endtask

  initial begin
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 2'd0, 3'd2, 5'd0, 1'b0, 1'b0);
    model_reset();
    #1;
    check_all("reset");
    @(negedge clk);
    rst = 1'b1;

    // ALU write-back
    drive(1'b1, 1'b0, 1'b0, 32'h2, 32'h0, 32'h100, 32'h0, 2'd0, 3'd2, 5'd5, 1'b1, 1'b0);
    cycle("alu");
    chk("alu_data_const", dataD_o, 32'h2);
    chk("alu_pc_const", pc_o, 32'h104);
    chk("alu_instret_const", instret_o, 32'h1);

    // Loads with byte/halfword selection
    drive(1'b1, 1'b0, 1'b0, 32'h1, 32'h8000_80F0, 32'h10, 32'h0, 2'd1, 3'd0, 5'd3, 1'b1, 1'b0);
    cycle("lb");
    chk("lb_const", dataD_o, 32'hFFFF_FF80);
    load_type_i = 3'd4;
    cycle("lbu");
    chk("lbu_const", dataD_o, 32'h0000_0080);
    alu_i = 32'h2; load_type_i = 3'd1;
    cycle("lh");
    chk("lh_const", dataD_o, 32'hFFFF_8000);
    load_type_i = 3'd5;
    cycle("lhu");
    chk("lhu_const", dataD_o, 32'h0000_8000);
    load_type_i = 3'd6;
    cycle("lw_reserved");
    chk("lw_reserved_const", dataD_o, 32'h8000_80F0);

    // Jump target with bit 0 cleared, link value, then PC wrap
    drive(1'b1, 1'b0, 1'b0, 32'h203, 32'h0, 32'h40, 32'h0, 2'd2, 3'd2, 5'd1, 1'b1, 1'b1);
    cycle("jump");
    chk("jump_pc_const", pc_o, 32'h202);
    chk("jump_link_const", dataD_o, 32'h44);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'hFFFF_FFFC, 32'h0, 2'd0, 3'd2, 5'd1, 1'b1, 1'b0);
    cycle("wrap");
    chk("wrap_pc_const", pc_o, 32'h0);

    // Flush wins over stall; then stall alone freezes everything
    drive(1'b1, 1'b1, 1'b1, 32'h55, 32'h0, 32'h300, 32'hABC, 2'd3, 3'd2, 5'd9, 1'b1, 1'b0);
    cycle("flush_stall");
    chk("flush_valid_const", {31'd0, valid_o}, 32'd0);
    drive(1'b1, 1'b0, 1'b0, 32'h55, 32'h0, 32'h300, 32'hABC, 2'd3, 3'd2, 5'd9, 1'b1, 1'b0);
    cycle("lui");
    stall_i = 1'b1; alu_i = 32'h77; rd_i = 5'd12;
    for (int i = 0; i < 3; i++) cycle("stall");
    chk("stall_data_const", dataD_o, 32'hABC);

    // Write to x0 retires but does not write the register file
    drive(1'b1, 1'b0, 1'b0, 32'h7, 32'h0, 32'h400, 32'h0, 2'd0, 3'd2, 5'd0, 1'b1, 1'b0);
    cycle("x0");
    chk("x0_we_const", {31'd0, reg_we_o}, 32'd0);

    // Asynchronous reset in the middle of a cycle
    drive(1'b1, 1'b0, 1'b0, 32'h9, 32'h0, 32'h500, 32'h0, 2'd0, 3'd2, 5'd4, 1'b1, 1'b0);
    cycle("pre_rst");
    #4;
    rst = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    @(negedge clk);
    rst = 1'b1;
    cycle("post_rst");

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      drive(($urandom_range(3, 0) != 0), ($urandom_range(4, 0) == 0), ($urandom_range(7, 0) == 0),
            $urandom, $urandom, $urandom, $urandom, 2'($urandom_range(3, 0)),
            3'($urandom_range(7, 0)), 5'($urandom_range(31, 0)), 1'($urandom_range(1, 0)),
            1'($urandom_range(1, 0)));
      cycle("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
